// File: rtl/nx_constants_pkg.sv
// Shared message type and direction indices for the NX message path.
package nx_constants;

    localparam int NX_MSG_W    = 32;
    localparam int NX_NUM_DIRS = 4;

    // Inbound stream indices; also the arbiter source numbering
    localparam int NX_DIR_N = 0;
    localparam int NX_DIR_E = 1;
    localparam int NX_DIR_S = 2;
    localparam int NX_DIR_W = 3;

    typedef logic [NX_MSG_W-1:0] nx_message_t;

endpackage

// File: rtl/nx_fifo.sv
// Small synchronous FIFO with combinational head read and registered status.
module nx_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A full buffer never pushes, so push+pop on full cannot occur
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem[rd_ptr];
    assign empty_o = (count == '0);
    assign full_o  = (count == CNT_W'(DEPTH));

    // Storage, pointers and occupancy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nx_msg_arbiter.sv
// Merges the four inbound message streams into one through per-source
// buffers, a round-robin arbiter and a single output register stage.
module nx_msg_arbiter
    import nx_constants::*;
#(
    parameter int STREAM_WIDTH = 32,
    parameter int SOURCES      = 4,
    parameter int BUF_DEPTH    = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    output logic                       idle_o,
    input  nx_message_t [SOURCES-1:0]  msg_data_i,
    input  logic [SOURCES-1:0]         msg_valid_i,
    output logic [SOURCES-1:0]         msg_ready_o,
    output nx_message_t                msg_data_o,
    output logic                       msg_valid_o,
    input  logic                       msg_ready_i,
    output logic [$clog2(SOURCES)-1:0] grant_o
);

    localparam int IDX_W = $clog2(SOURCES);

    logic [SOURCES-1:0] buf_empty;
    logic [SOURCES-1:0] buf_full;
    logic [SOURCES-1:0] buf_push;
    logic [SOURCES-1:0] buf_pop;
    nx_message_t        buf_data [SOURCES];
    logic [IDX_W-1:0]   last_q;
    logic [IDX_W-1:0]   grant_nxt;
    logic               load;

    // First non-empty buffer after the last grant, wrapping at SOURCES-1
    function automatic logic [IDX_W-1:0] rr_pick(input logic [IDX_W-1:0]   last,
                                                 input logic [SOURCES-1:0] empty);
        logic [IDX_W-1:0] cand;
        logic             found;
        rr_pick = last;
        found   = 1'b0;
        for (int k = 1; k <= SOURCES; k++) begin
            cand = IDX_W'((int'(last) + k) % SOURCES);
            if (!found && !empty[cand]) begin
                found   = 1'b1;
                rr_pick = cand;
            end
        end
    endfunction

    // Ready is buffer space only; held low while reset is asserted
    assign msg_ready_o = ~buf_full & {SOURCES{~rst_i}};
    assign buf_push    = msg_valid_i & msg_ready_o;
    assign idle_o      = (&buf_empty) && !msg_valid_o && !(|msg_valid_i);

    generate
        for (genvar s = 0; s < SOURCES; s++) begin : g_buf
            nx_fifo #(
                .DEPTH (BUF_DEPTH),
                .WIDTH (STREAM_WIDTH)
            ) u_fifo (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .push_i  (buf_push[s]),
                .data_i  (msg_data_i[s]),
                .pop_i   (buf_pop[s]),
                .data_o  (buf_data[s]),
                .empty_o (buf_empty[s]),
                .full_o  (buf_full[s])
            );
        end
    endgenerate

    // Arbitration and load decision for the output stage
    always_comb begin
        grant_nxt = rr_pick(last_q, buf_empty);
        load      = (!msg_valid_o || msg_ready_i) && !(&buf_empty);
        buf_pop   = load ? (SOURCES'(1) << grant_nxt) : '0;
    end

    // Output register: load on free slot, drop valid once drained
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            msg_valid_o <= 1'b0;
            msg_data_o  <= '0;
            grant_o     <= '0;
            last_q      <= IDX_W'(SOURCES - 1);
        end else if (load) begin
            msg_valid_o <= 1'b1;
            msg_data_o  <= buf_data[grant_nxt];
            grant_o     <= grant_nxt;
            last_q      <= grant_nxt;
        end else if (msg_ready_i) begin
            msg_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nx_msg_arbiter.sv
// Bench for nx_msg_arbiter: directed scenarios plus a long random run, all
// compared each cycle against a queue-based reference model.
module tb_nx_msg_arbiter;
    import nx_constants::*;

    localparam int SOURCES   = 4;
    localparam int BUF_DEPTH = 2;

    logic                clk = 1'b0;
    logic                rst_i;
    logic                idle_o;
    nx_message_t [3:0]   msg_data_i;
    logic [3:0]          msg_valid_i;
    logic [3:0]          msg_ready_o;
    nx_message_t         msg_data_o;
    logic                msg_valid_o;
    logic                msg_ready_i;
    logic [1:0]          grant_o;

    int errors = 0;
    int checks = 0;

    // Reference model: per-source queues, one output slot, last grant
    nx_message_t src_data [SOURCES];
    nx_message_t mq [SOURCES][$];
    bit          m_ov;
    nx_message_t m_data;
    int          m_grant;
    int          m_last;

    nx_msg_arbiter #(
        .STREAM_WIDTH (32),
        .SOURCES      (SOURCES),
        .BUF_DEPTH    (BUF_DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .idle_o      (idle_o),
        .msg_data_i  (msg_data_i),
        .msg_valid_i (msg_valid_i),
        .msg_ready_o (msg_ready_o),
        .msg_data_o  (msg_data_o),
        .msg_valid_o (msg_valid_o),
        .msg_ready_i (msg_ready_i),
        .grant_o     (grant_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SOURCES; s++) mq[s].delete();
        m_ov    = 1'b0;
        m_data  = '0;
        m_grant = 0;
        m_last  = SOURCES - 1;
    endtask

    function automatic logic [3:0] model_ready();
        logic [3:0] r;
        for (int s = 0; s < SOURCES; s++) r[s] = !rst_i && (mq[s].size() < BUF_DEPTH);
        return r;
    endfunction

    function automatic bit model_all_empty();
        bit e = 1'b1;
        for (int s = 0; s < SOURCES; s++) if (mq[s].size() != 0) e = 1'b0;
        return e;
    endfunction

    // Advance the model by one clock edge using the inputs present at the edge
    task automatic model_edge();
        logic [3:0] acc;
        bit         picked;
        if (rst_i) begin
            model_reset();
            return;
        end
        acc = msg_valid_i & model_ready();
        if ((!m_ov || msg_ready_i) && !model_all_empty()) begin
            picked = 1'b0;
            for (int k = 1; k <= SOURCES; k++) begin
                int idx = (m_last + k) % SOURCES;
                if (!picked && mq[idx].size() != 0) begin
                    picked  = 1'b1;
                    m_data  = mq[idx].pop_front();
                    m_grant = idx;
                    m_last  = idx;
                    m_ov    = 1'b1;
                end
            end
        end else if (msg_ready_i) begin
            m_ov = 1'b0;
        end
        for (int s = 0; s < SOURCES; s++) begin
            if (acc[s]) begin
                mq[s].push_back(src_data[s]);
                src_data[s] = src_data[s] + 1;
            end
        end
    endtask

    task automatic check_all();
        check_eq("ready",  64'(msg_ready_o), 64'(model_ready()));
        check_eq("valid",  64'(msg_valid_o), 64'(m_ov));
        check_eq("data",   64'(msg_data_o),  64'(m_data));
        check_eq("grant",  64'(grant_o),     64'(m_grant));
        check_eq("idle",   64'(idle_o),      64'(model_all_empty() && !m_ov && (msg_valid_i == 4'b0)));
    endtask

    // One clock: drive at the falling edge, check, then step the model
    task automatic cycle(input logic [3:0] v, input logic r);
        msg_valid_i = v;
        msg_ready_i = r;
        for (int s = 0; s < SOURCES; s++) msg_data_i[s] = src_data[s];
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        rst_i       = 1'b1;
        msg_valid_i = '0;
        msg_ready_i = 1'b0;
        msg_data_i  = '0;
        for (int s = 0; s < SOURCES; s++) src_data[s] = {8'(s), 24'h0};
        model_reset();

        // Reset state: ready low, idle high, output cleared
        cycle(4'h0, 1'b0);
        cycle(4'h0, 1'b0);
        cycle(4'hF, 1'b0);
        rst_i = 1'b0;

        // Single source on the south stream, two beats
        src_data[NX_DIR_S] = 32'hA000_0001;
        cycle(4'(1 << NX_DIR_S), 1'b1);
        cycle(4'(1 << NX_DIR_S), 1'b1);
        repeat (4) cycle(4'h0, 1'b1);

        // Fairness with all sources continuously valid
        repeat (12) cycle(4'hF, 1'b1);
        repeat (10) cycle(4'h0, 1'b1);

        // Backpressure, then release
        repeat (10) cycle(4'hF, 1'b0);
        repeat (12) cycle(4'h0, 1'b1);

        // Wrap-around: make west the last grant, then north and west together
        cycle(4'(1 << NX_DIR_W), 1'b1);
        repeat (3) cycle(4'h0, 1'b1);
        cycle(4'((1 << NX_DIR_N) | (1 << NX_DIR_W)), 1'b1);
        repeat (4) cycle(4'h0, 1'b1);

        // Mid-operation reset with several messages in flight
        cycle(4'hF, 1'b0);
        cycle(4'h1, 1'b0);
        cycle(4'h0, 1'b0);
        rst_i = 1'b1;
        model_reset();
        cycle(4'h0, 1'b0);
        cycle(4'hF, 1'b1);
        rst_i = 1'b0;
        cycle(4'h0, 1'b1);
        repeat (3) cycle(4'hF, 1'b1);
        repeat (10) cycle(4'h0, 1'b1);

        // Random valid/ready on all sources
        for (int i = 0; i < 10000; i++) begin
            cycle(4'($urandom()), ($urandom_range(0, 3) != 0));
        end
        repeat (20) cycle(4'h0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
